img2col_sched: RTL
==================

# img2col_sched

Sequencing controller for the 5×5 img2col stage. It latches one image and its convolution config on `start`, walks a k×k window across the image at stride 1 or 2, and emits one flattened patch (column) per window to the downstream MAC array over a valid/ready handshake. It sits between the image-tile buffer and the compute array.

## Interface

Parameters:
- `data_width`, default 8, pixel width in bits.
- `IMG_DIM`, default 5, image side length. Fixed at 5 for this revision.

Ports (reset is asynchronous and active-low):
- `clk` in, 1 bit, single clock, rising edge.
- `nrst` in, 1 bit, asynchronous active-low reset.
- `start` in, 1 bit, job request. Sampled only in IDLE.
- `k` in, 3 bits, kernel size. Legal values are 1..5.
- `stride` in, 1 bit, 0 selects stride 1 and 1 selects stride 2.
- `img` in, `[data_width-1:0] [4:0][4:0]`, image. Latched on an accepted `start`.
- `out_valid` out, 1 bit, patch available.
- `out_ready` in, 1 bit, downstream accepts the patch.
- `out_patch` out, `[data_width-1:0] [24:0]`, flattened window.
- `out_len` out, 5 bits, number of valid entries (k·k).
- `out_row`, `out_col` out, 3 bits each, window origin.
- `out_last` out, 1 bit, marks the final window of the job.
- `busy` out, 1 bit, high in RUN.
- `done` out, 1 bit, one-cycle pulse at job end.
- `err` out, 1 bit, one-cycle pulse when a job is rejected for an illegal `k`.
- `stall_cnt` out, 16 bits, stall counter. See Configuration.

## Operation

- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- **IDLE, `start`=1, k in 1..5:**
  - Latch `img`, `k` and `s` = `stride` ? 2 : 1.
  - Set row=0, col=0.
  - Go to RUN.
- **IDLE, `start`=1, k = 0 or k > 5:**
  - Pulse `err` for one cycle.
  - Stay in IDLE. No windows are emitted.
- **`start` outside IDLE:** ignored. Latched image and config do not change.
- **RUN, while `out_valid`=1:**
  - `out_patch[r*k+c]` = `img_q[row+r][col+c]` for r,c < k.
  - Entries at index ≥ k·k are 0.
- **RUN, on transfer (`out_valid` && `out_ready`):** compute the next window as follows.
  - If col+s+k ≤ 5: col += s.
  - Else if row+s+k ≤ 5: col = 0 and row += s.
  - Else (the window was last): go to DONE.
- **Output count:** `out_last` = 1 exactly when the current window satisfies col+s+k > 5 and row+s+k > 5. Windows per job = ((5−k)/s + 1)², using integer division.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **Mid-job reset:** asserting `nrst` low in any state returns to IDLE with every output at its reset value. The partial job is discarded.
- **Reset values:** `out_valid`, `busy`, `done`, `err`, `out_last`, `out_row`, `out_col`, `out_len`, `stall_cnt` and every entry of `out_patch` are 0.

## Timing

- `start` accepted on edge t gives `busy`=1 and `out_valid`=1 from t+1, with the window (0,0).
- All outputs are registered. `out_patch`, `out_len`, `out_row`, `out_col` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` does not drop without a transfer, except on reset.
- Throughput is one patch per cycle while `out_ready` is held high.
- The last transfer on edge n gives `done`=1, `busy`=0 and `out_valid`=0 on cycle n+1.
- IDLE is reached on n+2. The earliest next `start` is accepted in cycle n+2.
- `err` pulses in the cycle after the rejected `start` is sampled.

## Configuration

- Macro: `IMG2COL_SCHED_STALL_CNT_EN`.
- **Defined:**
  - `stall_cnt` increments on each cycle in RUN with `out_valid`=1 and `out_ready`=0.
  - It saturates at 16'hFFFF.
  - It clears to 0 on an accepted `start`.
  - It holds its value after DONE until the next accepted `start`.
- **Undefined:** `stall_cnt` is tied to 0 and the counter logic is absent. The port list does not change.

## Structure

- Package `img2col_pkg` holds:
  - `IMG_DIM` = 5 and `MAX_PATCH` = 25.
  - The state enum `sched_state_t` with values IDLE, RUN and DONE.
  - The stride-decode function.
  - The `patch_t` typedef, an array of 25 pixels.
- Sub-module `img2col_patch`: combinational gather from (`img_q`, row, col, k) to a zero-filled `patch_t`.
- The scheduler registers the gather output into `out_patch` whenever it loads a new window.

## Test plan

- **k=3, stride=0, `out_ready`=1:**
  - Exactly 9 patches with origins (0,0),(0,1),(0,2),(1,0)…(2,2).
  - `out_len`=9 and `out_last` only on (2,2).
  - Each patch matches the reference gather. With img[i][j]=5i+j, patch(1,1) = {6,7,8,11,12,13,16,17,18,0…}.
- **k=2, stride=1:**
  - 4 windows at (0,0),(0,2),(2,0),(2,2), with `out_len`=4.
  - `done` pulses 1 cycle after the 4th transfer.
- **k=5:** a single patch equal to the whole image in row-major order, with `out_last`=1.
- **k=3, stride=0, `out_ready` toggling 0,0,1:**
  - Patch data stays stable during the stalls. The total stays at 9.
  - With `IMG2COL_SCHED_STALL_CNT_EN`: `stall_cnt` = 18. Without the macro: `stall_cnt` = 0.
- **Illegal k and ignored start:**
  - k=0 → `err` pulse, no `out_valid`, `busy` stays 0.
  - k=6 → same result.
  - `start` during RUN → ignored; the job completes with the original config.
- **Reset mid-job:** `nrst` low after the 3rd patch of a k=3 job → all outputs are 0 immediately. A new `start` then restarts from (0,0).

Source files
------------

// File: rtl/img2col_pkg.sv
// Shared types and helpers for the img2col scheduler: image geometry, FSM states,
// stride decode and window-position arithmetic.
package img2col_pkg;

  localparam int IMG_DIM   = 5;
  localparam int MAX_PATCH = IMG_DIM * IMG_DIM;
  localparam int PIX_W     = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [MAX_PATCH-1:0] patch_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  function automatic logic [2:0] stride_dec(input logic stride);
    return stride ? 3'd2 : 3'd1;
  endfunction

  function automatic logic k_legal(input logic [2:0] k);
    return (k != 3'd0) && (k <= 3'(IMG_DIM));
  endfunction

  // Far edge of the window after one more step along an axis.
  function automatic logic [3:0] span(input logic [2:0] pos, input logic [2:0] s,
                                      input logic [2:0] k);
    return 4'(pos) + 4'(s) + 4'(k);
  endfunction

  function automatic logic win_last(input logic [2:0] row, input logic [2:0] col,
                                    input logic [2:0] s, input logic [2:0] k);
    return (span(col, s, k) > 4'(IMG_DIM)) && (span(row, s, k) > 4'(IMG_DIM));
  endfunction

endpackage

// File: rtl/img2col_patch.sv
// Combinational window gather: copies the k x k window at (row, col) into a
// row-major flattened patch, zero-filling every entry at index >= k*k.
module img2col_patch
  import img2col_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic [IMG_DIM-1:0][IMG_DIM-1:0][data_width-1:0] img_i,
  input  logic [2:0]                                      k_i,
  input  logic [2:0]                                      row_i,
  input  logic [2:0]                                      col_i,
  output logic [MAX_PATCH-1:0][data_width-1:0]            patch_o
);

  logic [3:0] ri;
  logic [3:0] ci;
  logic [5:0] idx;

  always_comb begin
    patch_o = '0;
    ri      = '0;
    ci      = '0;
    idx     = '0;
    for (int r = 0; r < IMG_DIM; r++) begin
      for (int c = 0; c < IMG_DIM; c++) begin
        ri  = 4'(row_i) + 4'(r);
        ci  = 4'(col_i) + 4'(c);
        idx = 6'(r) * 6'(k_i) + 6'(c);
        // Bounds guards keep illegal k values sampled in IDLE from indexing out of range.
        if ((3'(r) < k_i) && (3'(c) < k_i) && (ri < 4'(IMG_DIM)) &&
            (ci < 4'(IMG_DIM)) && (idx < 6'(MAX_PATCH))) begin
          patch_o[idx[4:0]] = img_i[ri[2:0]][ci[2:0]];
        end
      end
    end
  end

endmodule

// File: rtl/img2col_sched.sv
// img2col window scheduler: latches an image and kernel config on start and streams
// one flattened patch per window over valid/ready. Optional stall counter: IMG2COL_SCHED_STALL_CNT_EN.
module img2col_sched
  import img2col_pkg::*;
#(
  parameter int data_width = 8,
  parameter int IMG_DIM    = 5
) (
  input  logic                                            clk,
  input  logic                                            nrst,
  input  logic                                            start,
  input  logic [2:0]                                      k,
  input  logic                                            stride,
  input  logic [IMG_DIM-1:0][IMG_DIM-1:0][data_width-1:0] img,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [MAX_PATCH-1:0][data_width-1:0]            out_patch,
  output logic [4:0]                                      out_len,
  output logic [2:0]                                      out_row,
  output logic [2:0]                                      out_col,
  output logic                                            out_last,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            err,
  output logic [15:0]                                     stall_cnt
);

  sched_state_t                                    state_q;
  logic [IMG_DIM-1:0][IMG_DIM-1:0][data_width-1:0] img_q;
  logic [2:0]                                      k_q;
  logic [2:0]                                      s_q;
  logic [2:0]                                      row_q;
  logic [2:0]                                      col_q;
  logic                                            valid_q;
  logic [MAX_PATCH-1:0][data_width-1:0]            patch_q;
  logic [4:0]                                      len_q;
  logic                                            last_q;
  logic                                            busy_q;
  logic                                            done_q;
  logic                                            err_q;

  logic [2:0]                                      nxt_row_d;
  logic [2:0]                                      nxt_col_d;
  logic [IMG_DIM-1:0][IMG_DIM-1:0][data_width-1:0] g_img;
  logic [2:0]                                      g_k;
  logic [2:0]                                      g_row;
  logic [2:0]                                      g_col;
  logic [MAX_PATCH-1:0][data_width-1:0]            gather_patch;
  logic                                            start_ok;

  assign start_ok = start && k_legal(k);

  // Raster step: advance along the row, wrap to the next row band when the window would overrun.
  always_comb begin
    nxt_row_d = row_q;
    nxt_col_d = col_q + s_q;
    if (span(col_q, s_q, k_q) > 4'(IMG_DIM)) begin
      nxt_col_d = '0;
      nxt_row_d = row_q + s_q;
    end
  end

  // In IDLE the gather sees the incoming job so window (0,0) is ready the cycle after start.
  always_comb begin
    if (state_q == IDLE) begin
      g_img = img;
      g_k   = k;
      g_row = '0;
      g_col = '0;
    end else begin
      g_img = img_q;
      g_k   = k_q;
      g_row = nxt_row_d;
      g_col = nxt_col_d;
    end
  end

  img2col_patch #(
    .data_width(data_width)
  ) u_patch (
    .img_i  (g_img),
    .k_i    (g_k),
    .row_i  (g_row),
    .col_i  (g_col),
    .patch_o(gather_patch)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      img_q   <= '0;
      k_q     <= '0;
      s_q     <= 3'd1;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      patch_q <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (k_legal(k)) begin
              img_q   <= img;
              k_q     <= k;
              s_q     <= stride_dec(stride);
              row_q   <= '0;
              col_q   <= '0;
              patch_q <= gather_patch;
              len_q   <= 5'(k) * 5'(k);
              last_q  <= win_last(3'd0, 3'd0, stride_dec(stride), k);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q   <= nxt_row_d;
              col_q   <= nxt_col_d;
              patch_q <= gather_patch;
              last_q  <= win_last(nxt_row_d, nxt_col_d, s_q, k_q);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IMG2COL_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts backpressure cycles of the current job; held after DONE for software readout.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start_ok) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign out_valid = valid_q;
  assign out_patch = patch_q;
  assign out_len   = len_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
